// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector.
// Each channel passes its raw input through a synchroniser chain and then a
// debounce filter. Accepted edges are reported as one-cycle rise/fall pulses
// and as a sticky flag that is cleared per bit. irq is the OR of the sticky flags.
// Mode selects which edges are reported. The filter always tracks the input,
// whatever the mode, so enabling a channel later never reports an old edge.
module multi_edge_detector #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH-1:0]     signal_in,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH-1:0]     clr,
    output logic [CH-1:0]     rise_pulse,
    output logic [CH-1:0]     fall_pulse,
    output logic [CH-1:0]     edge_pulse,
    output logic [CH-1:0]     sticky,
    output logic              irq
);

    // The counter counts up to DEBOUNCE-1 at most, so it never wraps.
    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic                   filt_q;
            logic                   filt_d;
            logic [CW-1:0]          cnt_q;
            logic [CW-1:0]          cnt_d;
            logic                   rise_q;
            logic                   rise_d;
            logic                   fall_q;
            logic                   fall_d;
            logic                   sticky_q;
            logic                   sticky_d;
            logic                   sync_lvl;
            logic                   accept;

            // The last synchroniser stage is the first level that is safe to use.
            assign sync_lvl = sync_q[SYNC_STAGES-1];

            // Shift the raw input into the synchroniser chain.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], signal_in[gi]};
            end

            // Debounce: a new level is accepted only after it has differed from
            // the filtered level for DEBOUNCE consecutive cycles.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = cnt_q;
                accept = 1'b0;
                if (sync_lvl == filt_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    filt_d = sync_lvl;
                    cnt_d  = '0;
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Report accepted edges according to the mode; on the same edge a new
            // event takes priority over clr, so no event is lost.
            always_comb begin
                rise_d   = accept &  sync_lvl & mode[2*gi];
                fall_d   = accept & ~sync_lvl & mode[2*gi+1];
                sticky_d = (sticky_q & ~clr[gi]) | rise_d | fall_d;
            end

            // Channel state registers; reset clears everything at once.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q   <= '0;
                    filt_q   <= 1'b0;
                    cnt_q    <= '0;
                    rise_q   <= 1'b0;
                    fall_q   <= 1'b0;
                    sticky_q <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    filt_q   <= filt_d;
                    cnt_q    <= cnt_d;
                    rise_q   <= rise_d;
                    fall_q   <= fall_d;
                    sticky_q <= sticky_d;
                end
            end

            assign rise_pulse[gi] = rise_q;
            assign fall_pulse[gi] = fall_q;
            assign sticky[gi]     = sticky_q;
        end
    endgenerate

    assign edge_pulse = rise_pulse | fall_pulse;
    assign irq        = |sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector with the default parameters (CH=4, SYNC_STAGES=2,
// DEBOUNCE=4). Each cycle, the stimulus for that cycle is driven and the expected
// output word {rise, fall, sticky} is pushed to the scoreboard. On the next falling
// edge the word is popped and compared with the outputs.
// Index k of a loop means "after rising edge E(k+1)". An input driven at k=0
// therefore gives its pulse at k=5.
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] signal_in;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] edge_pulse;
    logic [3:0] sticky;
    logic       irq;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] sb[$];
    logic [3:0]  sticky_exp;

    multi_edge_detector #(.CH(4), .SYNC_STAGES(2), .DEBOUNCE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .signal_in  (signal_in),
        .mode       (mode),
        .clr        (clr),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_pulse (edge_pulse),
        .sticky     (sticky),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [11:0] exp_v;
        sticky_exp = 4'b0000;
        sb.push_back(12'h000);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== 4'b0000 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got r=%b f=%b e=%b s=%b irq=%b, required all 0",
                     rise_pulse, fall_pulse, edge_pulse, sticky, irq);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sb.push_back({4'b0000, 4'b0000, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_reset done: %0d compared so far", n_cmp);
    endtask

    task automatic test_rise_latency();
        logic [11:0] exp_v;
        logic [3:0]  r;
        mode = 8'h55;
        for (int k = 0; k < 23; k++) begin
            if (k == 0)  signal_in[0] = 1'b1;
            if (k == 12) clr = 4'b0001;
            if (k == 13) clr = 4'b0000;
            if (k == 14) signal_in[0] = 1'b0;   // fall under rise-only mode: silent
            r = 4'b0000;
            if (k == 5)  begin r = 4'b0001; sticky_exp[0] = 1'b1; end
            if (k == 12) sticky_exp[0] = 1'b0;
            sb.push_back({r, 4'b0000, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL rise_latency k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_rise_latency done: %0d compared so far", n_cmp);
    endtask

    task automatic test_glitch();
        logic [11:0] exp_v;
        logic [3:0]  r;
        logic [3:0]  f;
        mode = 8'hFF;
        for (int k = 0; k < 29; k++) begin
            if (k == 0)  signal_in[1] = 1'b1;   // 3-cycle glitch
            if (k == 3)  signal_in[1] = 1'b0;
            if (k == 12) signal_in[1] = 1'b1;   // 4-cycle pulse: accepted
            if (k == 16) signal_in[1] = 1'b0;
            if (k == 26) clr = 4'b0010;
            if (k == 27) clr = 4'b0000;
            r = 4'b0000;
            f = 4'b0000;
            if (k == 17) begin r = 4'b0010; sticky_exp[1] = 1'b1; end
            if (k == 21) f = 4'b0010;
            if (k == 26) sticky_exp[1] = 1'b0;
            sb.push_back({r, f, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL glitch k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_glitch done: %0d compared so far", n_cmp);
    endtask

    task automatic test_mode_gating();
        logic [11:0] exp_v;
        logic [3:0]  f;
        mode = 8'h20;                            // ch2 fall only
        for (int k = 0; k < 69; k++) begin
            if (k == 0)  signal_in[2] = 1'b1;
            if (k == 10) signal_in[2] = 1'b0;
            if (k == 20) clr = 4'b0100;
            if (k == 21) clr = 4'b0000;
            if (k == 22) begin mode = 8'h00; signal_in[2] = 1'b1; end
            if (k == 32) signal_in[2] = 1'b0;
            if (k == 42) signal_in[2] = 1'b1;
            if (k == 52) mode = 8'h10;           // enable rise with level already high
            if (k == 60) signal_in[2] = 1'b0;    // fall under rise-only: silent
            f = 4'b0000;
            if (k == 15) begin f = 4'b0100; sticky_exp[2] = 1'b1; end
            if (k == 20) sticky_exp[2] = 1'b0;
            sb.push_back({4'b0000, f, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL mode_gating k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_mode_gating done: %0d compared so far", n_cmp);
    endtask

    task automatic test_sticky_race();
        logic [11:0] exp_v;
        logic [3:0]  r;
        logic [3:0]  f;
        mode = 8'hC0;                            // ch3 both edges
        for (int k = 0; k < 24; k++) begin
            if (k == 0)  signal_in[3] = 1'b1;
            if (k == 8)  clr = 4'b1000;
            if (k == 9)  clr = 4'b0000;
            if (k == 10) signal_in[3] = 1'b0;
            if (k == 15) clr = 4'b1000;          // lands on the fall accept edge
            if (k == 16) clr = 4'b0000;
            if (k == 20) clr = 4'b1000;
            if (k == 21) clr = 4'b0000;
            r = 4'b0000;
            f = 4'b0000;
            if (k == 5)  begin r = 4'b1000; sticky_exp[3] = 1'b1; end
            if (k == 8)  sticky_exp[3] = 1'b0;
            if (k == 15) begin f = 4'b1000; sticky_exp[3] = 1'b1; end
            if (k == 20) sticky_exp[3] = 1'b0;
            sb.push_back({r, f, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL sticky_race k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_sticky_race done: %0d compared so far", n_cmp);
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp_v;
        logic [3:0]  r;
        mode = 8'h01;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) signal_in[0] = 1'b1;
            r = 4'b0000;
            if (k == 5) begin r = 4'b0001; sticky_exp[0] = 1'b1; end
            sb.push_back({r, 4'b0000, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL reset_mid_pre k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        // Assert reset mid-cycle while rise_pulse[0] is high.
        #2;
        rst = 1'b0;
        sticky_exp = 4'b0000;
        sb.push_back(12'h000);
        #1;
        exp_v = sb.pop_front();
        n_cmp++;
        if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== 4'b0000 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got r=%b f=%b e=%b s=%b irq=%b, required all 0",
                     rise_pulse, fall_pulse, edge_pulse, sticky, irq);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 14; k++) begin
            r = 4'b0000;
            if (k == 5) begin r = 4'b0001; sticky_exp[0] = 1'b1; end
            sb.push_back({r, 4'b0000, sticky_exp});
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if ({rise_pulse, fall_pulse, sticky} !== exp_v || edge_pulse !== (exp_v[11:8] | exp_v[7:4]) || irq !== (|exp_v[3:0])) begin
                n_bad++;
                $display("FAIL reset_mid_post k=%0d: got r=%b f=%b e=%b s=%b irq=%b, required r=%b f=%b s=%b",
                         k, rise_pulse, fall_pulse, edge_pulse, sticky, irq, exp_v[11:8], exp_v[7:4], exp_v[3:0]);
            end
        end
        $display("test_reset_mid done: %0d compared so far", n_cmp);
    endtask

    initial begin
        rst        = 1'b0;
        signal_in  = 4'b0000;
        mode       = 8'h00;
        clr        = 4'b0000;
        sticky_exp = 4'b0000;
        test_reset();
        test_rise_latency();
        test_glitch();
        test_mode_gating();
        test_sticky_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
